// File: rtl/keypoint_scan_ctrl_if.sv
// Frame-buffer read port and 3x3x3 window port of the keypoint scan controller.
// master = controller side, slave = frame buffer / extrema comparator side.
interface keypoint_scan_ctrl_if #(
  parameter int AW = 19
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [47:0]   rd_data;
  logic          win_valid;
  logic          win_ready;
  logic [143:0]  win_d1;
  logic [143:0]  win_d2;
  logic [143:0]  win_d3;
  logic [15:0]   win_row;
  logic [15:0]   win_col;

  modport master (
    output rd_en, rd_addr, win_valid, win_d1, win_d2, win_d3, win_row, win_col,
    input  rd_data, win_ready
  );

  modport slave (
    input  rd_en, rd_addr, win_valid, win_d1, win_d2, win_d3, win_row, win_col,
    output rd_data, win_ready
  );
endinterface

// File: rtl/keypoint_scan_ctrl.sv
// Raster-scans interior pixels, fetching a 3x3x3 DoG window per centre; 11 cycles/window minimum.
// Window held stable while win_ready is low; optional stall counter under KP_SCAN_PERF_EN.
module keypoint_scan_ctrl #(
  parameter int N  = 450,
  parameter int M  = 600,
  parameter int AW = 19
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_done,
`ifdef KP_SCAN_PERF_EN
  output logic [31:0]          o_stall_cnt,
`endif
  keypoint_scan_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_DONE} state_t;

  localparam logic [15:0] LAST_ROW = 16'(N - 2);
  localparam logic [15:0] LAST_COL = 16'(M - 2);

  state_t        r_state;
  logic [15:0]   r_row;
  logic [15:0]   r_col;
  logic [3:0]    r_tap;
  logic [AW-1:0] r_base;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic          r_win_valid;
  logic [143:0]  r_d1;
  logic [143:0]  r_d2;
  logic [143:0]  r_d3;
  logic          r_busy;
  logic          r_done;
`ifdef KP_SCAN_PERF_EN
  logic [31:0]   r_stall_cnt;
`endif

  logic [3:0]    w_next_tap;
  logic [AW-1:0] w_next_addr;
  logic          w_col_wrap;
  logic          w_last;
  logic [AW-1:0] w_next_base;
  logic          w_cap_en;
  logic [3:0]    w_cap_tap;
  logic [7:0]    w_cap_lsb;

  // Offset of tap t from the window's top-left pixel address.
  function automatic logic [AW-1:0] tap_off(input logic [3:0] t);
    case (t)
      4'd0:    tap_off = '0;
      4'd1:    tap_off = AW'(1);
      4'd2:    tap_off = AW'(2);
      4'd3:    tap_off = AW'(M);
      4'd4:    tap_off = AW'(M + 1);
      4'd5:    tap_off = AW'(M + 2);
      4'd6:    tap_off = AW'(2 * M);
      4'd7:    tap_off = AW'(2 * M + 1);
      4'd8:    tap_off = AW'(2 * M + 2);
      default: tap_off = '0;
    endcase
  endfunction

  assign w_next_tap  = r_tap + 4'd1;
  assign w_next_addr = r_base + tap_off(w_next_tap);
  assign w_col_wrap  = (r_col == LAST_COL);
  assign w_last      = (r_row == LAST_ROW) && w_col_wrap;
  // Wrapping to the next row moves the top-left corner from col M-3 to col 0 one row down.
  assign w_next_base = w_col_wrap ? (r_base + AW'(3)) : (r_base + AW'(1));

  // Read data lags its strobe by one cycle: FETCH tap t lands tap t-1, WAIT lands tap 8.
  assign w_cap_en  = (r_state == S_WAIT) || ((r_state == S_FETCH) && (r_tap != 4'd0));
  assign w_cap_tap = (r_state == S_WAIT) ? 4'd8 : (r_tap - 4'd1);
  assign w_cap_lsb = {w_cap_tap, 4'b0000};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_tap       <= '0;
      r_base      <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_win_valid <= 1'b0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_d3        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef KP_SCAN_PERF_EN
      r_stall_cnt <= '0;
`endif
    end else begin
      if (w_cap_en) begin
        r_d1[w_cap_lsb +: 16] <= bus.rd_data[15:0];
        r_d2[w_cap_lsb +: 16] <= bus.rd_data[31:16];
        r_d3[w_cap_lsb +: 16] <= bus.rd_data[47:32];
      end

`ifdef KP_SCAN_PERF_EN
      if (r_win_valid && !bus.win_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
`endif

      if ((r_state != S_IDLE) && i_abort) begin
        r_state     <= S_IDLE;
        r_rd_en     <= 1'b0;
        r_win_valid <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state   <= S_FETCH;
              r_row     <= 16'd1;
              r_col     <= 16'd1;
              r_tap     <= 4'd0;
              r_base    <= '0;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
              r_busy    <= 1'b1;
`ifdef KP_SCAN_PERF_EN
              r_stall_cnt <= '0;
`endif
            end
          end

          S_FETCH: begin
            if (r_tap == 4'd8) begin
              r_state <= S_WAIT;
              r_rd_en <= 1'b0;
            end else begin
              r_tap     <= w_next_tap;
              r_rd_addr <= w_next_addr;
            end
          end

          S_WAIT: begin
            r_state     <= S_ISSUE;
            r_win_valid <= 1'b1;
          end

          S_ISSUE: begin
            if (bus.win_ready) begin
              r_win_valid <= 1'b0;
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_FETCH;
                r_tap     <= 4'd0;
                r_base    <= w_next_base;
                r_rd_addr <= w_next_base;
                r_rd_en   <= 1'b1;
                if (w_col_wrap) begin
                  r_col <= 16'd1;
                  r_row <= r_row + 16'd1;
                end else begin
                  r_col <= r_col + 16'd1;
                end
              end
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end

          default: begin
            r_state     <= S_IDLE;
            r_rd_en     <= 1'b0;
            r_win_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.win_valid = r_win_valid;
  assign bus.win_d1    = r_d1;
  assign bus.win_d2    = r_d2;
  assign bus.win_d3    = r_d3;
  assign bus.win_row   = r_row;
  assign bus.win_col   = r_col;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
`ifdef KP_SCAN_PERF_EN
  assign o_stall_cnt   = r_stall_cnt;
`endif

  a_addr_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_rd_en |-> (r_rd_addr <= AW'(N * M - 1)));

  a_rd_only_fetch: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_rd_en |-> (r_state == S_FETCH));

endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// Randomised bench for keypoint_scan_ctrl on a 4x5 frame against a raster-scan reference model.
// Inputs change and outputs are checked on the falling edge; memory answers one cycle after rd_en.
module tb_keypoint_scan_ctrl;
  localparam int N    = 4;
  localparam int M    = 5;
  localparam int AW   = 5;
  localparam int NWIN = (N - 2) * (M - 2);

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;
`ifdef KP_SCAN_PERF_EN
  logic [31:0] stall_cnt;
`endif

  keypoint_scan_ctrl_if #(.AW(AW)) bus ();

  keypoint_scan_ctrl #(.N(N), .M(M), .AW(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .o_busy      (busy),
    .o_done      (done),
`ifdef KP_SCAN_PERF_EN
    .o_stall_cnt (stall_cnt),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [47:0] mem [N*M];
  logic [47:0] pend;

  // reference model: where the scan is in the current cycle
  bit m_active;
  bit m_done_now;
  int m_cnt;
  int m_r;
  int m_c;
  int m_wins;
`ifdef KP_SCAN_PERF_EN
  logic [31:0] m_stall;
`endif

  // observations of the DUT
  bit           logging;
  int           hs_r[$];
  int           hs_c[$];
  int           addr_log[$];
  logic [143:0] first_d1;
  bit           first_seen;
  int           done_cnt;
  int           start_cyc;
  int           done_cyc;
  int           dut_hs;
  int           f_row;
  int           f_col;
  bit           f_seen;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int addr_of(input int r, input int c, input int t);
    return (r + t / 3 - 1) * M + (c + t % 3 - 1);
  endfunction

  function automatic logic [143:0] win_exp(input int p, input int r, input int c);
    logic [143:0] v;
    logic [47:0]  w;
    v = '0;
    for (int t = 0; t < 9; t++) begin
      w = mem[addr_of(r, c, t)];
      v[16*t +: 16] = w[16*p +: 16];
    end
    return v;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_done_now = 1'b0;
    m_cnt      = 0;
    m_r        = 0;
    m_c        = 0;
    m_wins     = 0;
`ifdef KP_SCAN_PERF_EN
    m_stall    = '0;
`endif
  endtask

  task automatic fill_random();
    for (int a = 0; a < N * M; a++) mem[a] = rand48();
  endtask

  task automatic step(input bit st, input bit ab, input bit rdy);
    bit e_rd;
    bit e_vld;
    @(negedge clk);
    cyc++;
    e_rd  = m_active && (m_cnt >= 1) && (m_cnt <= 9);
    e_vld = m_active && (m_cnt >= 11);
    chk("rd_en", 144'(bus.rd_en), 144'(e_rd));
    if (e_rd) chk("rd_addr", 144'(bus.rd_addr), 144'(addr_of(m_r, m_c, m_cnt - 1)));
    chk("win_valid", 144'(bus.win_valid), 144'(e_vld));
    if (e_vld) begin
      chk("win_row", 144'(bus.win_row), 144'(m_r));
      chk("win_col", 144'(bus.win_col), 144'(m_c));
      chk("win_d1", bus.win_d1, win_exp(0, m_r, m_c));
      chk("win_d2", bus.win_d2, win_exp(1, m_r, m_c));
      chk("win_d3", bus.win_d3, win_exp(2, m_r, m_c));
    end
    chk("busy", 144'(busy), 144'(m_active || m_done_now));
    chk("done", 144'(done), 144'(m_done_now));
`ifdef KP_SCAN_PERF_EN
    chk("stall_cnt", 144'(stall_cnt), 144'(m_stall));
`endif

    if (bus.win_valid && rdy && !ab) dut_hs++;
    if (bus.win_valid && !f_seen) begin
      f_row  = int'(bus.win_row);
      f_col  = int'(bus.win_col);
      f_seen = 1'b1;
    end
    if (logging) begin
      if (bus.rd_en && addr_log.size() < 9) addr_log.push_back(int'(bus.rd_addr));
      if (bus.win_valid && !first_seen) begin
        first_d1   = bus.win_d1;
        first_seen = 1'b1;
      end
      if (bus.win_valid && rdy && !ab) begin
        hs_r.push_back(int'(bus.win_row));
        hs_c.push_back(int'(bus.win_col));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end

    bus.rd_data   = pend;
    pend          = bus.rd_en ? mem[bus.rd_addr] : rand48();
    start         = st;
    abort         = ab;
    bus.win_ready = rdy;

    // advance the model to the next cycle
`ifdef KP_SCAN_PERF_EN
    if (e_vld && !rdy && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
`endif
    if ((m_active || m_done_now) && ab) begin
      m_active   = 1'b0;
      m_done_now = 1'b0;
    end else if (m_done_now) begin
      m_done_now = 1'b0;
    end else if (m_active) begin
      if (e_vld && rdy) begin
        m_wins++;
        if (m_r == N - 2 && m_c == M - 2) begin
          m_active   = 1'b0;
          m_done_now = 1'b1;
        end else begin
          if (m_c < M - 2) m_c++;
          else begin
            m_c = 1;
            m_r++;
          end
          m_cnt = 1;
        end
      end else begin
        m_cnt++;
      end
    end else if (st) begin
      start_cyc = cyc;
      m_active  = 1'b1;
      m_cnt     = 1;
      m_r       = 1;
      m_c       = 1;
      m_wins    = 0;
`ifdef KP_SCAN_PERF_EN
      m_stall   = '0;
`endif
    end
  endtask

  task automatic run_frame(input int rdy_pct, input int ab_pm, input int st_pct, input bit stall7);
    int guard;
    bit r;
    bit a;
    bit s;
    dut_hs = 0;
    f_seen = 1'b0;
    f_row  = 0;
    f_col  = 0;
    step(1'b1, 1'b0, 1'b1);
    guard = 0;
    while ((m_active || m_done_now) && guard < 1000) begin
      r = ($urandom_range(99) < rdy_pct);
      a = ($urandom_range(999) < ab_pm);
      s = ($urandom_range(99) < st_pct);
      if (stall7 && m_wins == 1 && m_cnt >= 11 && m_cnt <= 17) r = 1'b0;
      step(s, a, r);
      guard++;
    end
    if (guard >= 1000) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: frame still running after %0d cycles, limit 1000", guard);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [143:0] exp_d1;
    int           exp_addr[9];
    int           exp_hr[6];
    int           exp_hc[6];
    int           guard;

    exp_d1   = {16'd12, 16'd11, 16'd10, 16'd7, 16'd6, 16'd5, 16'd2, 16'd1, 16'd0};
    exp_addr = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    exp_hr   = '{1, 1, 1, 2, 2, 2};
    exp_hc   = '{1, 2, 3, 1, 2, 3};

    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    bus.win_ready = 1'b0;
    bus.rd_data   = '0;
    pend          = '0;
    logging       = 1'b0;
    first_seen    = 1'b0;
    done_cnt      = 0;
    start_cyc     = 0;
    done_cyc      = 0;
    model_reset();
    for (int a = 0; a < N * M; a++) mem[a] = {16'(a), 16'(a), 16'(a)};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 144'(bus.rd_en), 144'(0));
    chk("rst_rd_addr", 144'(bus.rd_addr), 144'(0));
    chk("rst_win_valid", 144'(bus.win_valid), 144'(0));
    chk("rst_win_d1", bus.win_d1, 144'(0));
    chk("rst_win_row", 144'(bus.win_row), 144'(0));
    chk("rst_win_col", 144'(bus.win_col), 144'(0));
    chk("rst_busy", 144'(busy), 144'(0));
    chk("rst_done", 144'(done), 144'(0));
    #2 rst_n = 1'b1;

    // frame A: address-valued memory, comparator always ready
    logging = 1'b1;
    run_frame(100, 0, 0, 1'b0);
    logging = 1'b0;
    chk("A_windows", 144'(hs_r.size()), 144'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < hs_r.size()) begin
        chk("A_centre_row", 144'(hs_r[i]), 144'(exp_hr[i]));
        chk("A_centre_col", 144'(hs_c[i]), 144'(exp_hc[i]));
      end
    end
    chk("A_addr_count", 144'(addr_log.size()), 144'(9));
    for (int i = 0; i < 9; i++) begin
      if (i < addr_log.size()) chk("A_first_addr", 144'(addr_log[i]), 144'(exp_addr[i]));
    end
    chk("A_first_d1", first_d1, exp_d1);
    chk("A_done_pulses", 144'(done_cnt), 144'(1));
    chk("A_start_to_done", 144'(done_cyc - start_cyc), 144'(67));

    // frame B: 7-cycle stall on window 2, stray start pulses
    fill_random();
    run_frame(100, 0, 20, 1'b1);
    chk("B_windows", 144'(dut_hs), 144'(NWIN));
`ifdef KP_SCAN_PERF_EN
    chk("B_stall_cnt", 144'(stall_cnt), 144'(7));
`endif

    // abort during FETCH of tap 4
    fill_random();
    step(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (m_cnt != 5 && guard < 50) begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("abort_rd_en", 144'(bus.rd_en), 144'(0));
    chk("abort_busy", 144'(busy), 144'(0));
    done_cnt = 0;
    logging  = 1'b1;
    repeat (5) step(1'b0, 1'b0, 1'b1);
    logging  = 1'b0;
    chk("abort_no_done", 144'(done_cnt), 144'(0));
    run_frame(100, 0, 0, 1'b0);
    chk("restart_row", 144'(f_row), 144'(1));
    chk("restart_col", 144'(f_col), 144'(1));
    chk("restart_windows", 144'(dut_hs), 144'(NWIN));

    // random backpressure, stray starts and occasional aborts
    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_frame(60, 8, 10, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'($urandom_range(1)));
    end

    // asynchronous reset while a window is being offered
    fill_random();
    step(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_cnt < 11 && guard < 50) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", 144'(bus.rd_en), 144'(0));
    chk("mid_rst_rd_addr", 144'(bus.rd_addr), 144'(0));
    chk("mid_rst_win_valid", 144'(bus.win_valid), 144'(0));
    chk("mid_rst_win_d1", bus.win_d1, 144'(0));
    chk("mid_rst_win_d2", bus.win_d2, 144'(0));
    chk("mid_rst_win_d3", bus.win_d3, 144'(0));
    chk("mid_rst_win_row", 144'(bus.win_row), 144'(0));
    chk("mid_rst_win_col", 144'(bus.win_col), 144'(0));
    chk("mid_rst_busy", 144'(busy), 144'(0));
    chk("mid_rst_done", 144'(done), 144'(0));
`ifdef KP_SCAN_PERF_EN
    chk("mid_rst_stall", 144'(stall_cnt), 144'(0));
`endif
    #1 rst_n = 1'b1;
    model_reset();
    start = 1'b0;
    abort = 1'b0;
    pend  = rand48();
    run_frame(80, 0, 0, 1'b0);
    chk("post_rst_row", 144'(f_row), 144'(1));
    chk("post_rst_col", 144'(f_col), 144'(1));
    chk("post_rst_windows", 144'(dut_hs), 144'(NWIN));
    repeat (3) step(1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypoint_scan_ctrl.md
KEYPOINT_SCAN_CTRL -- requirements
Module: keypoint_scan_ctrl

Interface
REQ-001 Parameters SHALL be: N, 450, image rows; M, 600, image columns; AW, 19, read address width (N*M <= 2^AW).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; begins a frame scan when idle.
REQ-005 abort  input  1  synchronous stop of an in-progress scan.
REQ-006 rd_en  output  1  frame-buffer read strobe.
REQ-007 rd_addr  output  AW  frame-buffer word address, row-major (row*M+col).
REQ-008 rd_data  input  48  {Diff3,Diff2,Diff1}, valid exactly one cycle after rd_en.
REQ-009 win_valid  output  1  3x3x3 window available to the extrema comparator.
REQ-010 win_ready  input  1  comparator accepts the window.
REQ-011 win_d1, win_d2, win_d3  output  144 each  nine 16-bit taps per plane, tap t at bits [16t+15:16t], t = 3*dr+dc.
REQ-012 win_row, win_col  output  16 each  centre pixel coordinates.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the last window is accepted.

Function
REQ-015 States SHALL be IDLE, FETCH, WAIT, ISSUE, DONE.
REQ-016 IDLE: start=1 -> FETCH with centre (row,col)=(1,1), tap index 0; start is ignored in all other states.
REQ-017 FETCH: one read per cycle for taps 0..8, rd_en=1, rd_addr=(row+dr-1)*M+(col+dc-1), dr=t/3, dc=t%3; after tap 8 -> WAIT.
REQ-018 rd_data returned in the cycle after the read of tap t SHALL be written to tap t of win_d1/d2/d3 (bits [15:0]/[31:16]/[47:32] respectively).
REQ-019 WAIT: one cycle capturing tap 8, rd_en=0 -> ISSUE.
REQ-020 ISSUE: win_valid=1; win_d*, win_row and win_col SHALL remain stable until win_valid&&win_ready.
REQ-021 On handshake: col<M-2 -> col+1; else col=1 and row+1; then -> FETCH; if (row,col)=(N-2,M-2) -> DONE instead.
REQ-022 DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
REQ-023 Minimum per-window latency SHALL be 11 cycles (9 FETCH + 1 WAIT + 1 ISSUE with win_ready=1); a frame yields exactly (N-2)*(M-2) windows.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE next cycle, drop win_valid and rd_en, and produce no done pulse; abort in IDLE has no effect.
REQ-025 abort and win_ready in the same cycle: abort wins; the window counts as not accepted.
REQ-026 rd_en SHALL be 0 outside FETCH; rd_addr SHALL never exceed N*M-1.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE and set rd_en, rd_addr, win_valid, win_d1/d2/d3, win_row, win_col, busy, done, and internal counters to 0.
REQ-028 Reset mid-scan SHALL discard all progress; the next start rescans from (1,1).

Configuration
REQ-029 With KP_SCAN_PERF_EN defined, a 32-bit output stall_cnt SHALL exist, cleared to 0 on reset and on accepted start, incremented each cycle with win_valid=1 and win_ready=0, saturating at 0xFFFFFFFF.
REQ-030 Without KP_SCAN_PERF_EN the port stall_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 N=4, M=5, win_ready tied 1, start pulse -> 6 windows, centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3), done pulses once, 66 cycles from start to done-1.
REQ-032 Memory preloaded word=address in all planes, N=4, M=5 -> first window win_d1 taps = 0,1,2,5,6,7,10,11,12; first rd_addr sequence identical.
REQ-033 win_ready held 0 for 7 cycles on window 2 -> win_* stable throughout, no rd_en, stall_cnt=7 with KP_SCAN_PERF_EN.
REQ-034 abort asserted during FETCH tap 4 -> IDLE next cycle, rd_en=0, busy=0, no done; subsequent start restarts at (1,1).
REQ-035 rst_n pulsed low mid-ISSUE -> all outputs 0 immediately; start pulse during scan ignored (window count unchanged).
